// File: rtl/bank_load_ctrl_pkg.sv
// Shared defaults and state encoding for the bank load controller.
package bank_load_ctrl_pkg;

  localparam int unsigned DefDepth = 8;
  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefSelW  = 3;

  typedef enum logic [1:0] {
    StFill  = 2'd0,
    StFlush = 2'd1,
    StFull  = 2'd2
  } state_e;

endpackage

// File: rtl/bank_load_ctrl.sv
// Streams bytes into a staged register bank, one slot per accept, and reports
// when the whole frame is resident so the array can consume it.
module bank_load_ctrl
  import bank_load_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned SEL_W  = DefSelW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              restart,
  input  logic              consume,
  output logic              bank_enable,
  output logic [DATA_W-1:0] bank_data,
  output logic [SEL_W-1:0]  bank_select,
  output logic              full,
  output logic [SEL_W:0]    fill_count,
  output logic              protocol_err
);

  state_e state_q, state_d;

  logic [SEL_W-1:0] wr_ptr_q;
  logic [SEL_W-1:0] bank_select_q;
  logic [SEL_W:0]   fill_count_q;
  logic             protocol_err_q;

  logic accept;
  logic last_slot;

  // restart wins over an offered byte, so it masks the accept.
  assign accept    = in_ready && in_valid && !restart;
  assign last_slot = (wr_ptr_q == SEL_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = StFill;
    end else begin
      unique case (state_q)
        StFill:  if (accept && last_slot) state_d = StFlush;
        StFlush: state_d = StFull;
        StFull:  if (consume) state_d = StFill;
        default: state_d = StFill;
      endcase
    end
  end

  always_comb begin
    in_ready    = reset && (state_q == StFill);
    full        = (state_q == StFull);
    bank_enable = accept;
    bank_data   = in_data;
  end

  // The bank stages data for one cycle, so the select registers the pointer
  // on the accept edge and is held otherwise while the bank reloads that slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q       <= '0;
      bank_select_q  <= '0;
      fill_count_q   <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      if (restart) begin
        wr_ptr_q     <= '0;
        fill_count_q <= '0;
      end else if (accept) begin
        bank_select_q <= wr_ptr_q;
        wr_ptr_q      <= last_slot ? '0 : wr_ptr_q + SEL_W'(1);
        fill_count_q  <= fill_count_q + (SEL_W + 1)'(1);
      end else if (state_q == StFull && consume) begin
        fill_count_q <= '0;
      end

      if (!restart && consume && state_q != StFull) begin
        protocol_err_q <= 1'b1;
      end
    end
  end

  assign bank_select  = bank_select_q;
  assign fill_count   = fill_count_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_bank_load_ctrl.sv
// Directed bench for bank_load_ctrl with a behavioural staged register bank.
module tb_bank_load_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       restart;
  logic       consume;
  logic       bank_enable;
  logic [7:0] bank_data;
  logic [2:0] bank_select;
  logic       full;
  logic [3:0] fill_count;
  logic       protocol_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [8];
  logic [7:0] staged;

  bank_load_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .restart      (restart),
    .consume      (consume),
    .bank_enable  (bank_enable),
    .bank_data    (bank_data),
    .bank_select  (bank_select),
    .full         (full),
    .fill_count   (fill_count),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  // Bank: samples data when enabled, reloads the selected slot every cycle.
  always @(posedge clk) begin
    mem[bank_select] <= staged;
    if (bank_enable) staged <= bank_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_consume();
    consume = 1'b1;
    tick();
    consume = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h99;
    restart  = 1'b0;
    consume  = 1'b0;
    repeat (2) tick();

    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_bank_enable", bank_enable, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_fill_count", fill_count, 0);
    check_eq("rst_bank_select", bank_select, 0);
    check_eq("rst_protocol_err", protocol_err, 0);

    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check_eq("idle_in_ready", in_ready, 1);

    // Back-to-back fill 0x11..0x88.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h11 * (i + 1));
      #1;
      if (i == 0) begin
        check_eq("b2b_enable", bank_enable, 1);
        check_eq("b2b_data", bank_data, 8'h11);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check_eq("flush_full", full, 0);
    check_eq("flush_in_ready", in_ready, 0);
    check_eq("b2b_fill_count", fill_count, 8);
    check_eq("b2b_bank_select", bank_select, 7);
    tick();
    check_eq("b2b_full", full, 1);
    for (int i = 0; i < 8; i++) check_eq("b2b_slot", mem[i], 32'(8'h11 * (i + 1)));

    // Byte offered while FULL must not be taken.
    in_valid = 1'b1;
    in_data  = 8'hEE;
    #1;
    check_eq("full_in_ready", in_ready, 0);
    check_eq("full_bank_enable", bank_enable, 0);
    tick();
    in_valid = 1'b0;
    check_eq("full_hold_count", fill_count, 8);
    check_eq("full_hold_slot7", mem[7], 8'h88);

    // Consume then refill 0xA0..0xA7 with valid toggling.
    pulse_consume();
    check_eq("cons_full", full, 0);
    check_eq("cons_fill_count", fill_count, 0);
    check_eq("cons_protocol_err", protocol_err, 0);
    check_eq("cons_in_ready", in_ready, 1);
    for (int c = 0; c < 16; c++) begin
      if (c % 2 == 0) begin
        in_valid = 1'b1;
        in_data  = 8'(8'hA0 + c / 2);
      end else begin
        in_valid = 1'b0;
        in_data  = 8'hFF;
      end
      tick();
      if (c == 3) check_eq("bp_fill_count", fill_count, 2);
      if (c == 3) check_eq("bp_bank_select", bank_select, 1);
      if (c == 14) check_eq("bp_flush_ready", in_ready, 0);
      if (c == 14) check_eq("bp_flush_full", full, 0);
    end
    in_valid = 1'b0;
    check_eq("bp_full", full, 1);
    check_eq("bp_fill_count8", fill_count, 8);
    for (int i = 0; i < 8; i++) check_eq("refill_slot", mem[i], 32'(8'hA0 + i));

    // Restart after three accepts.
    pulse_consume();
    send(8'h31);
    send(8'h32);
    send(8'h33);
    restart  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    #1;
    check_eq("rs_no_accept", bank_enable, 0);
    tick();
    restart  = 1'b0;
    in_valid = 1'b0;
    check_eq("rs_fill_count", fill_count, 0);
    check_eq("rs_bank_select", bank_select, 2);
    for (int i = 0; i < 8; i++) begin
      send(8'(8'hC0 + i));
      if (i == 0) check_eq("rs_first_select", bank_select, 0);
      if (i == 6) check_eq("rs_full_early", full, 0);
    end
    check_eq("rs_flush_full", full, 0);
    tick();
    check_eq("rs_full", full, 1);
    check_eq("rs_slot0", mem[0], 8'hC0);
    check_eq("rs_slot2", mem[2], 8'hC2);

    // Consume during FILL at fill_count 5.
    pulse_consume();
    for (int i = 0; i < 5; i++) send(8'(8'hD0 + i));
    check_eq("pe_count5", fill_count, 5);
    consume  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hD5;
    tick();
    consume  = 1'b0;
    in_valid = 1'b0;
    check_eq("pe_flag", protocol_err, 1);
    check_eq("pe_count6", fill_count, 6);
    send(8'hD6);
    send(8'hD7);
    tick();
    check_eq("pe_full", full, 1);
    check_eq("pe_sticky", protocol_err, 1);
    check_eq("pe_slot5", mem[5], 8'hD5);

    // Reset mid-fill after four accepts.
    pulse_consume();
    check_eq("pe_sticky2", protocol_err, 1);
    for (int i = 0; i < 4; i++) send(8'(8'h41 + i));
    check_eq("rm_count4", fill_count, 4);
    in_valid = 1'b1;
    in_data  = 8'h77;
    #2;
    reset = 1'b0;
    #1;
    check_eq("rm_fill_count", fill_count, 0);
    check_eq("rm_bank_select", bank_select, 0);
    check_eq("rm_full", full, 0);
    check_eq("rm_in_ready", in_ready, 0);
    check_eq("rm_bank_enable", bank_enable, 0);
    check_eq("rm_protocol_err", protocol_err, 0);
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    send(8'h5A);
    check_eq("rm_count1", fill_count, 1);
    check_eq("rm_select0", bank_select, 0);
    tick();
    check_eq("rm_slot0", mem[0], 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
